id_ex_stage: RTL and testbench

- ID/EX pipeline register and operand-select stage that directly feeds the ALU.
- Captures decoded operands and control from the ID stage.
- Translates funct3/funct7 into the 4-bit ALU control code.
- Resolves EX-stage data hazards with forwarding from EX/MEM and MEM/WB.
- Drives ALU src1/src2/aluctrl plus the side-band fields the EX/MEM register needs.

---
 rtl/id_ex_stage.sv | 168 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand-select stage.
// Optional forwarding from EX/MEM and MEM/WB is enabled by defining ID_EX_FORWARD_EN.
module id_ex_stage #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [1:0]         id_op_kind,
    input  logic               id_use_pc,
    input  logic [2:0]         id_funct3,
    input  logic               id_funct7b5,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [XLEN-1:0]    id_pc,
    input  logic               id_regwrite,
    input  logic               stall,
    input  logic               flush,
    input  logic               exm_regwrite,
    input  logic [RADDR_W-1:0] exm_rd,
    input  logic [XLEN-1:0]    exm_result,
    input  logic               mwb_regwrite,
    input  logic [RADDR_W-1:0] mwb_rd,
    input  logic [XLEN-1:0]    mwb_data,
    output logic [XLEN-1:0]    alu_src1,
    output logic [XLEN-1:0]    alu_src2,
    output logic [3:0]         alu_ctrl,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [XLEN-1:0]    ex_store_data,
    output logic               ex_illegal
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0011,
        ALU_XOR = 4'b0100,
        ALU_SLT = 4'b0101,
        ALU_SLL = 4'b0110,
        ALU_SRL = 4'b0111,
        ALU_SRA = 4'b1000
    } alu_op_e;

    alu_op_e dec_ctrl;
    logic    dec_illegal;

    alu_op_e            ctrl_q;
    logic               valid_q;
    logic               regwrite_q;
    logic               illegal_q;
    logic               use_pc_q;
    logic               use_imm_q;
    logic [RADDR_W-1:0] rd_q;
    logic [RADDR_W-1:0] rs1_addr_q;
    logic [RADDR_W-1:0] rs2_addr_q;
    logic [XLEN-1:0]    rs1_data_q;
    logic [XLEN-1:0]    rs2_data_q;
    logic [XLEN-1:0]    imm_q;
    logic [XLEN-1:0]    pc_q;

    logic [XLEN-1:0]    fwd_rs1;
    logic [XLEN-1:0]    fwd_rs2;
    logic [XLEN-1:0]    op2;
    logic               is_shift;

    always_comb begin
        dec_ctrl    = ALU_ADD;
        dec_illegal = 1'b0;
        case (id_op_kind)
            2'b00, 2'b01: begin
                case (id_funct3)
                    3'b000: dec_ctrl = (id_op_kind == 2'b00 && id_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001: dec_ctrl = ALU_SLL;
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: begin
                        dec_ctrl    = ALU_ADD;
                        dec_illegal = 1'b1;
                    end
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: dec_ctrl = id_funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110: dec_ctrl = ALU_OR;
                    default: dec_ctrl = ALU_AND;
                endcase
            end
            2'b10:   dec_ctrl = ALU_ADD;
            default: dec_ctrl = ALU_SUB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            // reset leaves alu_ctrl at AND (0000); a flush bubble shows ADD
            ctrl_q     <= rst ? ALU_AND : ALU_ADD;
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            illegal_q  <= 1'b0;
            use_pc_q   <= 1'b0;
            use_imm_q  <= 1'b0;
            rd_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
        end else if (!stall) begin
            ctrl_q     <= dec_ctrl;
            valid_q    <= id_valid;
            regwrite_q <= id_valid & id_regwrite;
            illegal_q  <= id_valid & dec_illegal;
            use_pc_q   <= id_use_pc;
            use_imm_q  <= (id_op_kind == 2'b01) || (id_op_kind == 2'b10);
            rd_q       <= id_rd_addr;
            rs1_addr_q <= id_rs1_addr;
            rs2_addr_q <= id_rs2_addr;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
            pc_q       <= id_pc;
        end
    end

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (exm_regwrite && exm_rd == rs1_addr_q && rs1_addr_q != '0)
            fwd_rs1 = exm_result;
        else if (mwb_regwrite && mwb_rd == rs1_addr_q && rs1_addr_q != '0)
            fwd_rs1 = mwb_data;
    end

    always_comb begin
        fwd_rs2 = rs2_data_q;
        if (exm_regwrite && exm_rd == rs2_addr_q && rs2_addr_q != '0)
            fwd_rs2 = exm_result;
        else if (mwb_regwrite && mwb_rd == rs2_addr_q && rs2_addr_q != '0)
            fwd_rs2 = mwb_data;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{exm_regwrite, exm_rd, exm_result, mwb_regwrite, mwb_rd, mwb_data,
                          rs1_addr_q, rs2_addr_q};
    assign fwd_rs1 = rs1_data_q;
    assign fwd_rs2 = rs2_data_q;
`endif

    // the ALU shifts by all of src2, so the shift amount is trimmed here
    assign is_shift = (ctrl_q == ALU_SLL) || (ctrl_q == ALU_SRL) || (ctrl_q == ALU_SRA);
    assign op2      = use_imm_q ? imm_q : fwd_rs2;

    assign alu_src1      = use_pc_q ? pc_q : fwd_rs1;
    assign alu_src2      = is_shift ? {{(XLEN-5){1'b0}}, op2[4:0]} : op2;
    assign alu_ctrl      = ctrl_q;
    assign ex_valid      = valid_q;
    assign ex_regwrite   = regwrite_q;
    assign ex_rd         = rd_q;
    assign ex_store_data = fwd_rs2;
    assign ex_illegal    = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding expectations follow ID_EX_FORWARD_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [1:0]  id_op_kind;
    logic        id_use_pc;
    logic [2:0]  id_funct3;
    logic        id_funct7b5;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic        id_regwrite;
    logic        stall, flush;
    logic        exm_regwrite;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        mwb_regwrite;
    logic [4:0]  mwb_rd;
    logic [31:0] mwb_data;
    logic [31:0] alu_src1, alu_src2, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic        ex_valid, ex_regwrite, ex_illegal;
    logic [4:0]  ex_rd;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_op_kind(id_op_kind),
        .id_use_pc(id_use_pc), .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_regwrite(id_regwrite), .stall(stall), .flush(flush),
        .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_regwrite(mwb_regwrite), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd),
        .ex_store_data(ex_store_data), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic upc, input logic [2:0] f3,
                         input logic f7, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc);
        id_valid = 1'b1; id_regwrite = 1'b1;
        id_op_kind = op; id_use_pc = upc; id_funct3 = f3; id_funct7b5 = f7;
        id_rs1_addr = a1; id_rs2_addr = a2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        exm_regwrite = 1'b0; exm_rd = '0; exm_result = '0;
        mwb_regwrite = 1'b0; mwb_rd = '0; mwb_data = '0;
        drive(2'b00, 1'b0, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h55, 32'h66, 32'h77, 32'h88);
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
        checks++; if (alu_ctrl !== 4'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", alu_ctrl); end
        checks++; if (ex_regwrite !== 1'b0 || ex_illegal !== 1'b0 || ex_rd !== 5'd0) begin
            errors++; $display("FAIL reset_side got rw=%0b ill=%0b rd=%0d exp 0/0/0", ex_regwrite, ex_illegal, ex_rd); end
        checks++; if (alu_src1 !== 32'h0 || alu_src2 !== 32'h0 || ex_store_data !== 32'h0) begin
            errors++; $display("FAIL reset_ops got %h %h %h exp 0 0 0", alu_src1, alu_src2, ex_store_data); end
    endtask

    task automatic test_rtype_sub();
        drive(2'b00, 1'b0, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'h10, 32'h3, 32'h0, 32'h0);
        step();
        checks++; if (alu_ctrl !== 4'b0011) begin errors++; $display("FAIL sub_ctrl got %h exp 3", alu_ctrl); end
        checks++; if (alu_src1 !== 32'h10 || alu_src2 !== 32'h3) begin
            errors++; $display("FAIL sub_ops got %h %h exp 10 3", alu_src1, alu_src2); end
        checks++; if (ex_valid !== 1'b1 || ex_regwrite !== 1'b1 || ex_rd !== 5'd3) begin
            errors++; $display("FAIL sub_side got v=%0b rw=%0b rd=%0d exp 1/1/3", ex_valid, ex_regwrite, ex_rd); end
        checks++; if (ex_store_data !== 32'h3) begin errors++; $display("FAIL sub_store got %h exp 3", ex_store_data); end
    endtask

    task automatic test_srai();
        drive(2'b01, 1'b0, 3'b101, 1'b1, 5'd4, 5'd0, 5'd9, 32'h8000_0000, 32'h0, 32'hFFFF_FFE4, 32'h0);
        step();
        checks++; if (alu_ctrl !== 4'b1000) begin errors++; $display("FAIL srai_ctrl got %h exp 8", alu_ctrl); end
        checks++; if (alu_src2 !== 32'h4) begin errors++; $display("FAIL srai_src2 got %h exp 4", alu_src2); end
        checks++; if (alu_src1 !== 32'h8000_0000) begin errors++; $display("FAIL srai_src1 got %h exp 80000000", alu_src1); end
    endtask

    typedef struct {
        logic [1:0]  op;  logic upc; logic [2:0] f3; logic f7;
        logic [31:0] d1;  logic [31:0] d2; logic [31:0] imm; logic [31:0] pc;
        logic [3:0]  ctrl; logic [31:0] s1; logic [31:0] s2; logic [31:0] st;
    } vec_t;

    task automatic test_decode();
        vec_t v [10];
        v[0] = '{2'b00, 1'b0, 3'b001, 1'b0, 32'h1, 32'h123, 32'h0, 32'h0, 4'h6, 32'h1, 32'h3, 32'h123};
        v[1] = '{2'b00, 1'b0, 3'b101, 1'b0, 32'h2, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'h7, 32'h2, 32'h1F, 32'hFFFF_FFFF};
        v[2] = '{2'b01, 1'b0, 3'b000, 1'b1, 32'h3, 32'h9, 32'h5, 32'h0, 4'h2, 32'h3, 32'h5, 32'h9};
        v[3] = '{2'b01, 1'b0, 3'b010, 1'b0, 32'h4, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'h5, 32'h4, 32'hFFFF_FFFF, 32'h0};
        v[4] = '{2'b00, 1'b0, 3'b110, 1'b0, 32'h5, 32'h6, 32'h0, 32'h0, 4'h1, 32'h5, 32'h6, 32'h6};
        v[5] = '{2'b00, 1'b0, 3'b111, 1'b0, 32'h7, 32'h8, 32'h0, 32'h0, 4'h0, 32'h7, 32'h8, 32'h8};
        v[6] = '{2'b00, 1'b0, 3'b100, 1'b0, 32'hA, 32'hB, 32'h0, 32'h0, 4'h4, 32'hA, 32'hB, 32'hB};
        v[7] = '{2'b10, 1'b0, 3'b010, 1'b1, 32'h100, 32'h77, 32'h40, 32'h0, 4'h2, 32'h100, 32'h40, 32'h77};
        v[8] = '{2'b11, 1'b0, 3'b001, 1'b0, 32'h20, 32'h29, 32'h0, 32'h0, 4'h3, 32'h20, 32'h29, 32'h29};
        v[9] = '{2'b01, 1'b1, 3'b000, 1'b0, 32'h5, 32'h0, 32'h10, 32'h1000, 4'h2, 32'h1000, 32'h10, 32'h0};
        for (int i = 0; i < 10; i++) begin
            drive(v[i].op, v[i].upc, v[i].f3, v[i].f7, 5'd1, 5'd2, 5'd3, v[i].d1, v[i].d2, v[i].imm, v[i].pc);
            step();
            checks++; if (alu_ctrl !== v[i].ctrl) begin errors++; $display("FAIL dec%0d_ctrl got %h exp %h", i, alu_ctrl, v[i].ctrl); end
            checks++; if (alu_src1 !== v[i].s1 || alu_src2 !== v[i].s2 || ex_store_data !== v[i].st) begin
                errors++; $display("FAIL dec%0d_ops got %h %h %h exp %h %h %h", i, alu_src1, alu_src2,
                                   ex_store_data, v[i].s1, v[i].s2, v[i].st); end
        end
    endtask

    task automatic test_forward();
        logic [31:0] e1, e2, e3;
`ifdef ID_EX_FORWARD_EN
        e1 = 32'hAA; e2 = 32'hBB; e3 = 32'hBB;
`else
        e1 = 32'h11; e2 = 32'h11; e3 = 32'h22;
`endif
        drive(2'b00, 1'b0, 3'b000, 1'b0, 5'd5, 5'd6, 5'd7, 32'h11, 32'h22, 32'h0, 32'h0);
        step();
        stall = 1'b1;
        exm_regwrite = 1'b1; exm_rd = 5'd5; exm_result = 32'hAA;
        mwb_regwrite = 1'b1; mwb_rd = 5'd5; mwb_data = 32'hBB;
        #1;
        checks++; if (alu_src1 !== e1) begin errors++; $display("FAIL fwd_exm got %h exp %h", alu_src1, e1); end
        checks++; if (alu_src2 !== 32'h22) begin errors++; $display("FAIL fwd_rs2_untouched got %h exp 22", alu_src2); end
        exm_regwrite = 1'b0;
        #1;
        checks++; if (alu_src1 !== e2) begin errors++; $display("FAIL fwd_mwb got %h exp %h", alu_src1, e2); end
        mwb_rd = 5'd6;
        #1;
        checks++; if (ex_store_data !== e3 || alu_src2 !== e3) begin
            errors++; $display("FAIL fwd_store got %h %h exp %h", ex_store_data, alu_src2, e3); end
        stall = 1'b0;
        exm_regwrite = 1'b1; exm_rd = 5'd0; mwb_rd = 5'd0;
        drive(2'b00, 1'b0, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7, 32'h33, 32'h44, 32'h0, 32'h0);
        step();
        checks++; if (alu_src1 !== 32'h33 || alu_src2 !== 32'h44) begin
            errors++; $display("FAIL fwd_x0 got %h %h exp 33 44", alu_src1, alu_src2); end
        exm_regwrite = 1'b0; mwb_regwrite = 1'b0;
    endtask

    task automatic test_stall_flush();
        drive(2'b01, 1'b0, 3'b000, 1'b0, 5'd1, 5'd2, 5'd7, 32'h100, 32'h0, 32'h20, 32'h0);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 1'b1, 3'b111, 1'b1, 5'd3, 5'd4, 5'(10 + i), 32'h900 + i, 32'h5, 32'h1, 32'h4000);
            step();
            checks++; if (ex_rd !== 5'd7 || alu_ctrl !== 4'h2 || ex_valid !== 1'b1) begin
                errors++; $display("FAIL stall%0d_ctrl got rd=%0d ctrl=%h v=%0b exp 7/2/1", i, ex_rd, alu_ctrl, ex_valid); end
            checks++; if (alu_src1 !== 32'h100 || alu_src2 !== 32'h20) begin
                errors++; $display("FAIL stall%0d_ops got %h %h exp 100 20", i, alu_src1, alu_src2); end
        end
        flush = 1'b1;
        step();
        checks++; if (ex_valid !== 1'b0 || alu_ctrl !== 4'b0010) begin
            errors++; $display("FAIL flush_bubble got v=%0b ctrl=%h exp 0/2", ex_valid, alu_ctrl); end
        checks++; if (ex_regwrite !== 1'b0 || ex_rd !== 5'd0 || ex_illegal !== 1'b0 || alu_src1 !== 32'h0) begin
            errors++; $display("FAIL flush_side got rw=%0b rd=%0d ill=%0b s1=%h exp 0/0/0/0",
                               ex_regwrite, ex_rd, ex_illegal, alu_src1); end
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_illegal();
        drive(2'b00, 1'b0, 3'b011, 1'b0, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 32'h0, 32'h0);
        step();
        checks++; if (ex_illegal !== 1'b1 || alu_ctrl !== 4'b0010) begin
            errors++; $display("FAIL ill_r got ill=%0b ctrl=%h exp 1/2", ex_illegal, alu_ctrl); end
        id_valid = 1'b0;
        step();
        checks++; if (ex_illegal !== 1'b0 || ex_regwrite !== 1'b0 || ex_valid !== 1'b0) begin
            errors++; $display("FAIL ill_invalid got ill=%0b rw=%0b v=%0b exp 0/0/0", ex_illegal, ex_regwrite, ex_valid); end
        drive(2'b01, 1'b0, 3'b011, 1'b0, 5'd1, 5'd2, 5'd8, 32'h1, 32'h2, 32'h3, 32'h0);
        step();
        checks++; if (ex_illegal !== 1'b1 || alu_ctrl !== 4'b0010) begin
            errors++; $display("FAIL ill_i got ill=%0b ctrl=%h exp 1/2", ex_illegal, alu_ctrl); end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_srai();
        test_decode();
        test_forward();
        test_stall_flush();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
